vram_arbiter: RTL

Owns the single port of the font/character block RAM and shares it between two requesters: pixel fetch (hard real-time reads) and the command processor (buffered writes). Also sequences a bulk memory-clear operation for the command processor. Sits between the command-processing FSM and the pixel generator in the display controller top level.

---
 rtl/vram_pkg.sv | 13 +
 rtl/vram_arbiter_fifo.sv | 40 ++++
 rtl/vram_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_arbiter shared types and defaults.
// Optional VRAM_STATS_EN adds a write-stall counter to the arbiter.
package vram_pkg;
  localparam int ADDR_W_D = 12;
  localparam int DATA_W_D = 8;
  localparam int RD_LAT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
endpackage

// File: rtl/vram_arbiter_fifo.sv
// wr_fifo2: two-entry in-order write buffer for the command side.
// Push is never offered when full; pop never when empty.
module wr_fifo2 #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(push) - 2'(pop);
    end
  end

  assign dout  = r_mem[r_rp];
  assign empty = (r_cnt == 2'd0);
  assign full  = r_cnt[1];
endmodule

// File: rtl/vram_arbiter.sv
// Single-port font RAM arbiter: pixel reads, buffered writes, bulk clear.
// Define VRAM_STATS_EN to add wr_stall_cnt.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_STATS_EN
  ,
  output logic [15:0]       wr_stall_cnt
`endif
);
  localparam int FW = ADDR_W + DATA_W;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_rdy_en;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_clr_val;

  logic [FW-1:0]     w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_wr_iss;
  logic              w_clr_iss;
  logic              w_clr_go;

  assign w_push    = wr_valid & wr_ready;
  assign w_wr_iss  = !rd_req & !w_empty;
  assign w_clr_iss = !rd_req & w_empty & (r_state == ST_CLEAR);
  assign w_clr_go  = clr_start & (r_state == ST_IDLE);

  // Ready is held low until the first edge after reset release.
  assign wr_ready = r_rdy_en & (r_state == ST_IDLE) & !w_full;
  assign busy     = (r_state != ST_IDLE);
  assign rd_data  = mem_rdata;

  wr_fifo2 #(.W(FW)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (w_push),
    .pop   (w_wr_iss),
    .din   ({wr_addr, wr_data}),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (clr_start)
          w_state_nx = (!w_empty || w_push) ? ST_DRAIN : ST_CLEAR;
      end
      ST_DRAIN: begin
        if (w_empty) w_state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (w_clr_iss && (&r_cnt)) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_rdy_en  <= 1'b0;
      r_cnt     <= '0;
      r_clr_val <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rdy_en <= 1'b1;
      if (w_clr_go) begin
        r_clr_val <= clr_value;
        r_cnt     <= '0;
      end else if (w_clr_iss) begin
        r_cnt <= r_cnt + 1'b1;
      end
      mem_re   <= rd_req;
      mem_we   <= w_wr_iss | w_clr_iss;
      rd_valid <= mem_re;
      if (rd_req) begin
        mem_addr <= rd_addr;
      end else if (w_wr_iss) begin
        mem_addr  <= w_head[FW-1:DATA_W];
        mem_wdata <= w_head[DATA_W-1:0];
      end else if (w_clr_iss) begin
        mem_addr  <= r_cnt;
        mem_wdata <= r_clr_val;
      end
    end
  end

`ifdef VRAM_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      r_stall <= '0;
    else if (rd_req && !w_empty && (r_stall != 16'hFFFF))
      r_stall <= r_stall + 16'd1;
  end

  assign wr_stall_cnt = r_stall;
`endif
endmodule
